// File: rtl/serial_tx_framed.sv
// Framed serial transmitter: start bit, DATA_W data bits, optional even parity,
// STOP_BITS stop bits. A one-entry holding register lets frames go out back-to-back.
module serial_tx_framed #(
    parameter int unsigned DATA_W    = 55,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic              Clk_S,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] TX_Data,
    input  logic              TX_Data_Valid,
    output logic              TX_Ready,
    output logic              S_Data,
    output logic              TX_Busy,
    output logic              Frame_Done
);

    localparam int unsigned CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                par_q, par_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                line_d;
    logic                done_d;
    logic                last_stop;
    logic                launch;
    logic                accept;

    // Frame boundary and handshake qualifiers
    assign last_stop = (state_q == STOP) && (cnt_q == CNT_W'(STOP_BITS - 1));
    assign launch    = hold_full_q && ((state_q == IDLE) || last_stop);
    assign accept    = TX_Data_Valid && TX_Ready;

    // Next-state, shifter, holding register and next line level
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        line_d      = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
                cnt_d   = '0;
            end
            STOP: begin
                if (last_stop) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Held word enters the shifter; parity is fixed here
        if (launch) begin
            state_d     = START;
            shreg_d     = hold_q;
            par_d       = ^hold_q;
            hold_full_d = 1'b0;
        end

        // Producer handover into the holding register
        if (accept) begin
            hold_d      = TX_Data;
            hold_full_d = 1'b1;
        end

        // Line level for the cycle that follows this edge
        case (state_d)
            START:   line_d = 1'b1;
            DATA:    line_d = (MSB_FIRST != 0) ? shreg_d[DATA_W-1] : shreg_d[0];
            PARITY:  line_d = par_d;
            default: line_d = 1'b0;
        endcase
    end

    // State and datapath registers, all outputs registered
    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            TX_Ready    <= 1'b0;
            S_Data      <= 1'b0;
            TX_Busy     <= 1'b0;
            Frame_Done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            TX_Ready    <= !hold_full_d;
            S_Data      <= line_d;
            TX_Busy     <= (state_d != IDLE);
            Frame_Done  <= done_d;
        end
    end

endmodule
